// File: rtl/dma_mc_controller.sv
// Multi-channel memory-to-accelerator DMA: per-channel descriptors, one shared read/write
// datapath, round-robin grants of up to BURST_BEATS beats each.
module dma_mc_controller #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned BURST_BEATS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     dma_busy,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_data_in,
  output logic                     acc_write,
  output logic [ADDR_W-1:0]        acc_addr,
  output logic [DATA_W-1:0]        acc_data_out,
  input  logic                     acc_ready
);

  localparam int unsigned BPB     = DATA_W / 8;
  localparam int unsigned BPB_LOG = $clog2(BPB);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BURST_W = $clog2(BURST_BEATS + 1);

  typedef enum logic [2:0] {StIdle, StArb, StRdReq, StRdWait, StWr} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_src   [NUM_CH];
  logic [ADDR_W-1:0]     r_dst   [NUM_CH];
  logic [LEN_W-1:0]      r_beats [NUM_CH];
  logic [LEN_W-1:0]      w_new_beats [NUM_CH];
  logic [NUM_CH-1:0]     r_busy;
  logic [NUM_CH-1:0]     r_zero_done;
  logic [CH_W-1:0]       r_grant;
  logic [CH_W-1:0]       r_ptr;
  logic [CH_W-1:0]       w_arb_grant;
  logic                  w_arb_found;
  logic [BURST_W-1:0]    r_burst;
  logic [DATA_W-1:0]     r_data;
  logic                  w_capture;
  logic                  w_accept;
  logic                  w_last;
  logic [NUM_CH-1:0]     w_grant_mask;
  logic                  w_others_busy;
  logic [31:0]           w_ptr_ext;

  assign w_grant_mask  = NUM_CH'(1) << r_grant;
  assign w_others_busy = |(r_busy & ~w_grant_mask);
  assign w_last        = (r_beats[r_grant] == LEN_W'(1));
  assign w_ptr_ext     = 32'(r_ptr);

  // Length rounded up to whole beats; one extra bit keeps the rounding add from overflowing.
  always_comb begin
    logic [LEN_W:0] w_len_rnd;
    w_len_rnd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_len_rnd      = {1'b0, ch_len[i*LEN_W +: LEN_W]} + (LEN_W+1)'(BPB - 1);
      w_new_beats[i] = LEN_W'(w_len_rnd >> BPB_LOG);
    end
  end

  // Round-robin: first busy channel at or after the pointer, wrapping.
  always_comb begin
    logic [31:0]     w_sum;
    logic [CH_W-1:0] w_idx;
    w_arb_found = 1'b0;
    w_arb_grant = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_sum = w_ptr_ext + k;
      if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
      w_idx = CH_W'(w_sum);
      if (!w_arb_found && r_busy[w_idx]) begin
        w_arb_found = 1'b1;
        w_arb_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    acc_write   = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle: if (|r_busy) w_state_nxt = StArb;
      StArb:  w_state_nxt = w_arb_found ? StRdReq : StIdle;
      StRdReq: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          if (mem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = StWr;
          end else begin
            w_state_nxt = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (mem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = StWr;
        end
      end
      StWr: begin
        acc_write = 1'b1;
        if (acc_ready) begin
          w_accept = 1'b1;
          if (w_last)                                       w_state_nxt = w_others_busy ? StArb : StIdle;
          else if (r_burst == BURST_W'(BURST_BEATS - 1))    w_state_nxt = StArb;
          else                                              w_state_nxt = StRdReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= '0;
      r_burst <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StArb && w_arb_found) begin
        r_grant <= w_arb_grant;
        r_ptr   <= (w_arb_grant == CH_W'(NUM_CH - 1)) ? '0 : w_arb_grant + 1'b1;
        r_burst <= '0;
      end else if (w_accept) begin
        r_burst <= r_burst + 1'b1;
      end
      if (w_capture) r_data <= mem_data_in;
    end
  end

  // A start on a busy channel loses to the beat update, so start+done on one channel is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= '0;
      r_zero_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_src[i]   <= '0;
        r_dst[i]   <= '0;
        r_beats[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_zero_done[i] <= 1'b0;
        if (ch_start[i] && !r_busy[i]) begin
          r_src[i]       <= ch_src_addr[i*ADDR_W +: ADDR_W];
          r_dst[i]       <= ch_dst_addr[i*ADDR_W +: ADDR_W];
          r_beats[i]     <= w_new_beats[i];
          r_busy[i]      <= (w_new_beats[i] != '0);
          r_zero_done[i] <= (w_new_beats[i] == '0);
        end else if (w_accept && r_grant == CH_W'(i)) begin
          r_src[i]   <= r_src[i] + ADDR_W'(BPB);
          r_dst[i]   <= r_dst[i] + ADDR_W'(BPB);
          r_beats[i] <= r_beats[i] - 1'b1;
          r_busy[i]  <= !w_last;
        end
      end
    end
  end

  assign ch_busy      = r_busy;
  assign dma_busy     = |r_busy;
  assign ch_done      = r_zero_done | ((w_accept && w_last) ? w_grant_mask : '0);
  assign mem_addr     = mem_read  ? r_src[r_grant] : '0;
  assign acc_addr     = acc_write ? r_dst[r_grant] : '0;
  assign acc_data_out = acc_write ? r_data : '0;

endmodule

// File: tb/tb_dma_mc_controller.sv
// Self-checking bench for dma_mc_controller: memory responder, read/write scoreboards,
// directed scenarios for bursts, arbitration, zero length, stalls, wrap and reset abort.
module tb_dma_mc_controller;
  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int LW     = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    ch_start;
  logic [NUM_CH*AW-1:0] ch_src_addr, ch_dst_addr;
  logic [NUM_CH*LW-1:0] ch_len;
  logic [NUM_CH-1:0]    ch_busy, ch_done;
  logic                 dma_busy, mem_read, mem_ready, mem_rvalid, acc_write, acc_ready;
  logic [31:0]          mem_addr, mem_data_in, acc_addr, acc_data_out;

  dma_mc_controller #(
    .NUM_CH(NUM_CH), .DATA_W(32), .ADDR_W(AW), .LEN_W(LW), .BURST_BEATS(8)
  ) dut (
    .clk(clk), .reset(reset), .ch_start(ch_start), .ch_src_addr(ch_src_addr),
    .ch_dst_addr(ch_dst_addr), .ch_len(ch_len), .ch_busy(ch_busy), .ch_done(ch_done),
    .dma_busy(dma_busy), .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_data_in(mem_data_in), .acc_write(acc_write),
    .acc_addr(acc_addr), .acc_data_out(acc_data_out), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory: same-cycle rvalid, or rvalid one cycle after the request is accepted.
  logic        same_mode;
  logic        pend;
  logic [31:0] pend_addr;
  assign mem_rvalid  = same_mode ? (mem_read && mem_ready) : pend;
  assign mem_data_in = same_mode ? mem_f(mem_addr) : mem_f(pend_addr);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (mem_read && mem_ready) begin
      pend      <= 1'b1;
      pend_addr <= mem_addr;
    end else begin
      pend      <= 1'b0;
    end
  end

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  logic [31:0] q_rd[$];
  wr_t         q_wr[$];
  int total = 0, bad = 0, rd_seen = 0, wr_seen = 0;
  int done_cnt[NUM_CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_read && mem_ready) begin
        rd_seen++;
        check_val("rd_expected", 32'(q_rd.size() != 0), 32'd1);
        if (q_rd.size() != 0) check_val("rd_addr", mem_addr, q_rd.pop_front());
      end
      if (acc_write && acc_ready) begin
        wr_t e;
        wr_seen++;
        check_val("wr_expected", 32'(q_wr.size() != 0), 32'd1);
        if (q_wr.size() != 0) begin
          e = q_wr.pop_front();
          check_val("wr_addr", acc_addr, e.a);
          check_val("wr_data", acc_data_out, e.d);
        end
      end
      for (int i = 0; i < NUM_CH; i++) if (ch_done[i]) done_cnt[i]++;
    end
  end

  task automatic set_ch(input int ch, input logic [31:0] src, input logic [31:0] dst,
                        input logic [15:0] len);
    ch_src_addr[ch*AW +: AW] = src;
    ch_dst_addr[ch*AW +: AW] = dst;
    ch_len[ch*LW +: LW]      = len;
  endtask

  task automatic push_beats(input logic [31:0] src, input logic [31:0] dst, input int first,
                            input int n);
    wr_t e;
    for (int k = first; k < first + n; k++) begin
      q_rd.push_back(src + 32'(4 * k));
      e.a = dst + 32'(4 * k);
      e.d = mem_f(src + 32'(4 * k));
      q_wr.push_back(e);
    end
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask);
    @(posedge clk) #1 ch_start = mask;
    @(posedge clk) #1 ch_start = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((dma_busy || q_wr.size() != 0) && n < budget) begin
      @(posedge clk) #1;
      n++;
    end
    check_val({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_wr(input string tag, input int target);
    int n = 0;
    while (wr_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_val({tag, "_wr_wait"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 32'({ch_busy, ch_done, dma_busy, mem_read, acc_write}), 32'd0);
    check_val({tag, "_maddr"}, mem_addr, 32'd0);
    check_val({tag, "_aaddr"}, acc_addr, 32'd0);
    check_val({tag, "_adata"}, acc_data_out, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, n;
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    reset = 1'b0; ch_start = '0; ch_src_addr = '0; ch_dst_addr = '0; ch_len = '0;
    mem_ready = 1'b1; acc_ready = 1'b1; same_mode = 1'b1;
    #12 check_all_zero("reset");
    @(posedge clk) #1 reset = 1'b1;

    // T2: two channels alternate 8-beat bursts, delayed read data.
    same_mode = 1'b0;
    w0 = wr_seen;
    set_ch(0, 32'h1000, 32'h8000, 16'd64);
    set_ch(1, 32'h2000, 32'h9000, 16'd64);
    push_beats(32'h1000, 32'h8000, 0, 8);
    push_beats(32'h2000, 32'h9000, 0, 8);
    push_beats(32'h1000, 32'h8000, 8, 8);
    push_beats(32'h2000, 32'h9000, 8, 8);
    pulse(4'b0011);
    check_val("t2_busy", 32'(ch_busy), 32'h3);
    wait_idle("t2", 2000);
    check_val("t2_writes", 32'(wr_seen - w0), 32'd32);
    check_val("t2_done0", 32'(done_cnt[0]), 32'd1);
    check_val("t2_done1", 32'(done_cnt[1]), 32'd1);

    // T1: single channel, zero-wait; a restart while busy must be ignored.
    same_mode = 1'b1;
    w0 = wr_seen; r0 = rd_seen;
    set_ch(0, 32'h0100, 32'h4000, 16'd32);
    push_beats(32'h0100, 32'h4000, 0, 8);
    pulse(4'b0001);
    check_val("t1_busy", 32'(ch_busy), 32'h1);
    repeat (5) @(posedge clk);
    set_ch(0, 32'h7700, 32'h7800, 16'd4);
    pulse(4'b0001);
    wait_idle("t1", 500);
    check_val("t1_writes", 32'(wr_seen - w0), 32'd8);
    check_val("t1_reads", 32'(rd_seen - r0), 32'd8);
    check_val("t1_done", 32'(done_cnt[0]), 32'd2);

    // T3: zero length completes next cycle with no bus activity.
    w0 = wr_seen; r0 = rd_seen;
    set_ch(2, 32'h0500, 32'h0600, 16'd0);
    @(posedge clk) #1 ch_start = 4'b0100;
    check_val("t3_pre_done", 32'(ch_done), 32'd0);
    @(posedge clk) #1 ch_start = '0;
    check_val("t3_done", 32'(ch_done), 32'h4);
    check_val("t3_busy", 32'(ch_busy), 32'd0);
    @(posedge clk) #1;
    check_val("t3_done_pulse", 32'(ch_done), 32'd0);
    repeat (4) @(posedge clk);
    check_val("t3_no_rd", 32'(rd_seen - r0), 32'd0);
    check_val("t3_no_wr", 32'(wr_seen - w0), 32'd0);
    check_val("t3_done_cnt", 32'(done_cnt[2]), 32'd1);

    // T4: five stalled write cycles on the third beat.
    w0 = wr_seen;
    set_ch(3, 32'h0700, 32'h0A00, 16'd16);
    push_beats(32'h0700, 32'h0A00, 0, 4);
    pulse(4'b1000);
    wait_wr("t4", w0 + 2);
    #1 acc_ready = 1'b0;
    n = 0;
    while (!acc_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("t4_wr_seen", 32'(acc_write), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_val("t4_stall_wr", 32'(acc_write), 32'd1);
      check_val("t4_stall_addr", acc_addr, 32'h0A08);
      check_val("t4_stall_data", acc_data_out, mem_f(32'h0708));
      check_val("t4_stall_cnt", 32'(wr_seen - w0), 32'd2);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk) #1 acc_ready = 1'b1;
    wait_idle("t4", 500);
    check_val("t4_writes", 32'(wr_seen - w0), 32'd4);
    check_val("t4_done", 32'(done_cnt[3]), 32'd1);

    // T5: source address wraps through zero.
    r0 = rd_seen;
    set_ch(1, 32'hFFFF_FFF8, 32'h0B00, 16'd16);
    q_rd.push_back(32'hFFFF_FFF8); q_rd.push_back(32'hFFFF_FFFC);
    q_rd.push_back(32'h0000_0000); q_rd.push_back(32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      wr_t e;
      e.a = 32'h0B00 + 32'(4 * k);
      e.d = mem_f(32'hFFFF_FFF8 + 32'(4 * k));
      q_wr.push_back(e);
    end
    pulse(4'b0010);
    wait_idle("t5", 500);
    check_val("t5_reads", 32'(rd_seen - r0), 32'd4);
    check_val("t5_done", 32'(done_cnt[1]), 32'd2);

    // T6: asynchronous reset after beat 3 aborts without a done.
    w0 = wr_seen; d0 = done_cnt[0];
    set_ch(0, 32'h2000, 32'h3000, 16'd32);
    push_beats(32'h2000, 32'h3000, 0, 8);
    pulse(4'b0001);
    wait_wr("t6", w0 + 3);
    #3 reset = 1'b0;
    #1 check_all_zero("t6_abort");
    q_rd.delete();
    q_wr.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check_val("t6_no_done", 32'(done_cnt[0]), 32'(d0));
    check_val("t6_busy_clr", 32'(ch_busy), 32'd0);
    set_ch(0, 32'h2100, 32'h3100, 16'd8);
    push_beats(32'h2100, 32'h3100, 0, 2);
    pulse(4'b0001);
    wait_idle("t6", 500);
    check_val("t6_done", 32'(done_cnt[0]), 32'(d0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
